// File: rtl/apb4_eg_pkg.sv
// Shared types and constants for the APB4 example initiator.
package apb4_eg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_RESP
    } state_t;

    localparam logic [2:0] PPROT_PRIV  = 3'b001;
    localparam logic [2:0] PPROT_NSEC  = 3'b010;
    localparam logic [2:0] PPROT_INSTR = 3'b100;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        timeout;
    } rsp_t;

    localparam rsp_t RSP_DEFAULT = '0;

endpackage

// File: rtl/apb4_eg_timeout_ctr.sv
// ACCESS-phase wait counter; expired flags the last allowed ACCESS cycle.
module apb4_eg_timeout_ctr #(
    parameter int TIMEOUT = 16
) (
    input  logic pclk,
    input  logic preset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [W-1:0] LAST = W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [W-1:0] count;

    always_ff @(posedge pclk) begin
        if (preset || clr) begin
            count <= '0;
        end else if (en && count != '1) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (TIMEOUT != 0) && (count == LAST);

endmodule

// File: rtl/apb4_eg_master.sv
// APB4 initiator: one valid/ready command becomes one SETUP/ACCESS transfer.
module apb4_eg_master
    import apb4_eg_pkg::*;
#(
    parameter int ADDRWIDTH = 12,
    parameter int TIMEOUT   = 16
) (
    input  logic                 pclk,
    input  logic                 preset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [ADDRWIDTH-1:0] cmd_addr,
    input  logic [31:0]          cmd_wdata,
    input  logic [3:0]           cmd_strb,
    input  logic [2:0]           cmd_prot,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_rdata,
    output logic                 rsp_err,
    output logic                 rsp_timeout,
    output logic [ADDRWIDTH-1:0] paddr,
    output logic                 psel,
    output logic                 penable,
    output logic                 pwrite,
    output logic [31:0]          pwdata,
    output logic [3:0]           pstrb,
    output logic [2:0]           pprot,
    input  logic [31:0]          prdata,
    input  logic                 pready,
    input  logic                 pslverr
);

    state_t state;
    logic   accept;
    logic   tmo_expired;

    assign accept = (state == ST_IDLE) && cmd_valid && cmd_ready;

    apb4_eg_timeout_ctr #(
        .TIMEOUT(TIMEOUT)
    ) u_tmo (
        .pclk    (pclk),
        .preset  (preset),
        .clr     (accept),
        .en      ((state == ST_ACCESS) && !pready),
        .expired (tmo_expired)
    );

    always_ff @(posedge pclk) begin
        if (preset) begin
            state     <= ST_IDLE;
            cmd_ready <= 1'b1;
            psel      <= 1'b0;
            penable   <= 1'b0;
            paddr     <= '0;
            pwrite    <= 1'b0;
            pwdata    <= '0;
            pstrb     <= '0;
            pprot     <= '0;
            rsp_valid <= 1'b0;
            {rsp_rdata, rsp_err, rsp_timeout} <= RSP_DEFAULT;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        paddr     <= cmd_addr;
                        pwrite    <= cmd_write;
                        pwdata    <= cmd_write ? cmd_wdata : '0;
                        pstrb     <= cmd_write ? cmd_strb : '0;
                        pprot     <= cmd_prot;
                        psel      <= 1'b1;
                        cmd_ready <= 1'b0;
                        state     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    penable <= 1'b1;
                    state   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    // pready takes priority over an expiring timeout on the same cycle
                    if (pready) begin
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= pslverr;
                        rsp_timeout <= 1'b0;
                        rsp_rdata   <= (!pwrite && !pslverr) ? prdata : '0;
                        state       <= ST_RESP;
                    end else if (tmo_expired) begin
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_rdata   <= '0;
                        state       <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb4_eg_master.sv
// Self-checking bench: directed vector table, reset corner case, random traffic.
module tb_apb4_eg_master;
    import apb4_eg_pkg::*;

    localparam int AW   = 12;
    localparam int TMO  = 8;

    logic          pclk = 1'b0;
    logic          preset;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [31:0]   cmd_wdata;
    logic [3:0]    cmd_strb;
    logic [2:0]    cmd_prot;
    logic          rsp_valid, rsp_ready;
    logic [31:0]   rsp_rdata;
    logic          rsp_err, rsp_timeout;
    logic [AW-1:0] paddr;
    logic          psel, penable, pwrite;
    logic [31:0]   pwdata;
    logic [3:0]    pstrb;
    logic [2:0]    pprot;
    logic [31:0]   prdata;
    logic          pready, pslverr;

    int checks = 0;
    int errors = 0;

    always #5 pclk = ~pclk;

    apb4_eg_master #(.ADDRWIDTH(AW), .TIMEOUT(TMO)) dut (
        .pclk(pclk), .preset(preset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
        .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    typedef struct {
        logic        wr;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
        int          waits;   // ACCESS cycles with pready low before pready rises
        logic        slverr;
        logic [31:0] rdv;
        int          hold;    // cycles rsp_ready is held low
        logic [31:0] e_rdata;
        logic        e_err;
        logic        e_to;
        int          e_acc;   // expected number of ACCESS cycles
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic wr, input logic [11:0] addr, input logic [31:0] wdata,
                                input logic [3:0] strb, input logic [2:0] prot, input int waits,
                                input logic slverr, input logic [31:0] rdv, input int hold,
                                input logic [31:0] e_rdata, input logic e_err, input logic e_to,
                                input int e_acc);
        vec_t v;
        v.wr = wr; v.addr = addr; v.wdata = wdata; v.strb = strb; v.prot = prot;
        v.waits = waits; v.slverr = slverr; v.rdv = rdv; v.hold = hold;
        v.e_rdata = e_rdata; v.e_err = e_err; v.e_to = e_to; v.e_acc = e_acc;
        return v;
    endfunction

    // Reference model: outcome of a transfer from the slave's behaviour alone.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        if (v.waits >= TMO) begin
            r.e_to = 1'b1; r.e_err = 1'b1; r.e_rdata = '0; r.e_acc = TMO;
        end else begin
            r.e_to = 1'b0; r.e_err = v.slverr;
            r.e_rdata = (v.wr || v.slverr) ? 32'h0 : v.rdv;
            r.e_acc = v.waits + 1;
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic do_xfer(input vec_t v);
        int acc = 0;
        logic [31:0] exp_wd;
        logic [3:0]  exp_st;
        exp_wd = v.wr ? v.wdata : 32'h0;
        exp_st = v.wr ? v.strb : 4'h0;
        chk("cmd_ready_idle", {31'h0, cmd_ready}, 32'h1);
        cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr;
        cmd_wdata = v.wdata; cmd_strb = v.strb; cmd_prot = v.prot;
        tick();
        cmd_valid = 1'b0; cmd_wdata = $urandom; cmd_addr = AW'($urandom);
        chk("setup_phase", {30'h0, psel, penable}, 32'h2);
        chk("setup_paddr", {20'h0, paddr}, {20'h0, v.addr});
        chk("setup_pwdata", pwdata, exp_wd);
        chk("setup_pstrb", {28'h0, pstrb}, {28'h0, exp_st});
        chk("setup_pwrite_pprot", {28'h0, pwrite, pprot}, {28'h0, v.wr, v.prot});
        chk("setup_cmd_ready", {31'h0, cmd_ready}, 32'h0);
        pready = 1'b0;
        tick();
        chk("access_latency", {30'h0, psel, penable}, 32'h3);
        for (int n = 0; n < 40; n++) begin
            if (!(psel && penable)) break;
            acc++;
            chk("access_stable", {pwrite, pprot, pstrb, 12'h0, paddr},
                {v.wr, v.prot, exp_st, 12'h0, v.addr});
            chk("access_pwdata", pwdata, exp_wd);
            pready  = (acc > v.waits);
            pslverr = pready && v.slverr;
            prdata  = pready ? v.rdv : $urandom;
            tick();
        end
        pready = 1'b0; pslverr = 1'b0;
        chk("access_cycles", acc, v.e_acc);
        chk("bus_released", {30'h0, psel, penable}, 32'h0);
        for (int h = 0; h <= v.hold; h++) begin
            chk("rsp_valid", {31'h0, rsp_valid}, 32'h1);
            chk("rsp_rdata", rsp_rdata, v.e_rdata);
            chk("rsp_err_to", {30'h0, rsp_err, rsp_timeout}, {30'h0, v.e_err, v.e_to});
            chk("rsp_no_cmd_ready", {31'h0, cmd_ready}, 32'h0);
            rsp_ready = (h == v.hold);
            cmd_valid = 1'b1;   // pending command must not be taken while in RESP
            tick();
            cmd_valid = 1'b0;
            if (h != v.hold) chk("rsp_hold_no_psel", {31'h0, psel}, 32'h0);
        end
        rsp_ready = 1'b0;
        chk("rsp_done", {30'h0, rsp_valid, cmd_ready}, 32'h1);
        chk("rsp_done_no_psel", {31'h0, psel}, 32'h0);
    endtask

    vec_t tbl[9];

    initial begin
        vec_t r;
        preset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_strb = '0; cmd_prot = '0; rsp_ready = 1'b0;
        prdata = '0; pready = 1'b0; pslverr = 1'b0;

        tbl[0] = mk(1, 12'h004, 32'hA5A55A5A, 4'hF, 3'b000, 0, 0, 32'h0,        0, 32'h0,        0, 0, 1);
        tbl[1] = mk(0, 12'h00C, 32'hFFFFFFFF, 4'hF, PPROT_PRIV, 2, 0, 32'h12345678, 0, 32'h12345678, 0, 0, 3);
        tbl[2] = mk(1, 12'hFD0, 32'h0BADF00D, 4'h3, PPROT_NSEC, 1, 1, 32'h0,     0, 32'h0,        1, 0, 2);
        tbl[3] = mk(0, 12'hFD0, 32'h0,        4'h0, 3'b000, 0, 1, 32'hDEADBEEF, 0, 32'h0,        1, 0, 1);
        tbl[4] = mk(0, 12'h010, 32'h0,        4'h0, PPROT_INSTR, 8, 0, 32'h55555555, 0, 32'h0,   1, 1, 8);
        tbl[5] = mk(0, 12'h014, 32'h0,        4'h0, 3'b000, 7, 0, 32'hCAFEF00D, 0, 32'hCAFEF00D, 0, 0, 8);
        tbl[6] = mk(1, 12'h020, 32'h01020304, 4'h5, 3'b011, 0, 0, 32'h0,        5, 32'h0,        0, 0, 1);
        tbl[7] = mk(0, 12'h023, 32'h0,        4'h0, 3'b000, 0, 0, 32'h00001111, 0, 32'h00001111, 0, 0, 1);
        tbl[8] = mk(1, 12'h030, 32'h77777777, 4'hF, 3'b000, 12, 0, 32'h0,       1, 32'h0,        1, 1, 8);

        tick(); tick();
        chk("reset_cmd_ready", {31'h0, cmd_ready}, 32'h1);
        chk("reset_ctrl", {28'h0, psel, penable, pwrite, rsp_valid}, 32'h0);
        chk("reset_rsp", {rsp_rdata[29:0], rsp_err, rsp_timeout}, 32'h0);
        chk("reset_bus", {pstrb, pprot, 13'h0, paddr}, 32'h0);
        chk("reset_pwdata", pwdata, 32'h0);
        preset = 1'b0;
        tick();

        for (int i = 0; i < 9; i++) do_xfer(tbl[i]);

        // Reset in the middle of ACCESS: transfer dropped, no response.
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h040; cmd_prot = 3'b001;
        tick();
        cmd_valid = 1'b0;
        tick(); tick(); tick();
        chk("pre_reset_access", {30'h0, psel, penable}, 32'h3);
        preset = 1'b1;
        tick();
        preset = 1'b0;
        chk("midreset_bus", {29'h0, psel, penable, rsp_valid}, 32'h0);
        chk("midreset_cmd_ready", {31'h0, cmd_ready}, 32'h1);
        tick();
        chk("midreset_no_rsp", {31'h0, rsp_valid}, 32'h0);
        do_xfer(model(mk(0, 12'h044, 32'h0, 4'h0, 3'b000, 1, 0, 32'h89ABCDEF, 0, 0, 0, 0, 0)));

        for (int k = 0; k < 40; k++) begin
            r = mk($urandom_range(0, 1), 12'($urandom), $urandom, 4'($urandom), 3'($urandom),
                   $urandom_range(0, 10), ($urandom_range(0, 3) == 0), $urandom,
                   $urandom_range(0, 3), 0, 0, 0, 0);
            do_xfer(model(r));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
